// File: rtl/hazard_sb.sv
// ---------------------------------------------------------------------------
// hazard_sb -- pipeline hazard unit with a latency scoreboard.
//
// Generates stall/flush controls for a five-stage F/D/E/M/W pipeline, selects
// operand forwarding sources for the E stage, and tracks long-latency
// producers (e.g. divider/multiplier results) in a per-register scoreboard.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_stall, d_stall              memory stall requests
//   div_stallE, mult_stallE       multi-cycle unit stall requests
//   rsD, rtD, rsE, rtE            source register indices in D and E
//   reg_write_enD/reg_writeD      destination of the instruction in D
//   lat_opD, lat_valD             D holds a long-latency producer / its latency
//   reg_write_en{E,M,W}           destination write enables in E/M/W
//   reg_write{E,M,W}              destination indices in E/M/W
//   loadE, loadM                  E/M instruction is a load
//   flush_pred_failedM            branch mispredict resolved in M
//   flush_exceptionM              exception taken in M
//   longest_stall                 OR of all stall requests
//   stall{F,D,E,M,W}              per-stage stall
//   flush{F,D,E,M,W}              per-stage flush
//   forward_aE, forward_bE        00 regfile, 01 from M, 10 from W
//   sb_busy                       scoreboard busy bits (bit 0 always 0)
// ---------------------------------------------------------------------------
module hazard_sb #(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int LW         = 3,
  parameter bit FWD_LOAD_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            d_stall,
  input  logic            div_stallE,
  input  logic            mult_stallE,
  input  logic [AW-1:0]   rsD,
  input  logic [AW-1:0]   rtD,
  input  logic [AW-1:0]   rsE,
  input  logic [AW-1:0]   rtE,
  input  logic            reg_write_enD,
  input  logic [AW-1:0]   reg_writeD,
  input  logic            lat_opD,
  input  logic [LW-1:0]   lat_valD,
  input  logic            reg_write_enE,
  input  logic [AW-1:0]   reg_writeE,
  input  logic            reg_write_enM,
  input  logic [AW-1:0]   reg_writeM,
  input  logic            reg_write_enW,
  input  logic [AW-1:0]   reg_writeW,
  input  logic            loadE,
  input  logic            loadM,
  input  logic            flush_pred_failedM,
  input  logic            flush_exceptionM,
  output logic            longest_stall,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            stallW,
  output logic            flushF,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            flushW,
  output logic [1:0]      forward_aE,
  output logic [1:0]      forward_bE,
  output logic [NREG-1:0] sb_busy
);

  localparam logic [LW-1:0] CNT_ONE = LW'(1);

  logic            ld_haz_e;
  logic            ld_haz_m;
  logic            ld_hazD;
  logic            sb_hazD;
  logic            hazD;
  logic            alloc;
  logic            pending_redirect_reg;
  logic            pending_redirect_next;
  logic [NREG-1:0] busy_vec;

  // Forwarding source for one E-stage operand. A load still in M can only
  // be forwarded from M when the memory returns data early enough.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0 && reg_write_enM && src == reg_writeM && (FWD_LOAD_M || !loadM))
      sel = 2'b01;
    else if (src != '0 && reg_write_enW && src == reg_writeW)
      sel = 2'b10;
    return sel;
  endfunction

  assign forward_aE = fwd_sel(rsE);
  assign forward_bE = fwd_sel(rtE);

  assign longest_stall = i_stall | d_stall | div_stallE | mult_stallE;

  // Load-use: the consumer in D must wait until the load data is forwardable.
  assign ld_haz_e = loadE && reg_write_enE && (reg_writeE != '0) &&
                    ((reg_writeE == rsD) || (reg_writeE == rtD));
  assign ld_haz_m = !FWD_LOAD_M && loadM && reg_write_enM && (reg_writeM != '0) &&
                    ((reg_writeM == rsD) || (reg_writeM == rtD));
  assign ld_hazD  = ld_haz_e | ld_haz_m;

  assign sb_hazD = ((rsD != '0) && busy_vec[rsD]) || ((rtD != '0) && busy_vec[rtD]);

  // A flush from M squashes the D instruction anyway, so it must not stall.
  assign hazD = (ld_hazD | sb_hazD) & ~flush_exceptionM & ~flush_pred_failedM;

  assign stallF = longest_stall | hazD;
  assign stallD = longest_stall | hazD;
  assign stallE = longest_stall;
  assign stallM = longest_stall;
  assign stallW = longest_stall;

  assign flushF = 1'b0;
  assign flushD = flush_exceptionM;
  assign flushE = flush_exceptionM |
                  ((flush_pred_failedM | pending_redirect_reg | hazD) & ~longest_stall);
  assign flushM = flush_exceptionM;
  assign flushW = 1'b0;

  // Allocation happens only when the D instruction actually advances.
  assign alloc = !stallD && !flush_exceptionM && lat_opD && reg_write_enD &&
                 (reg_writeD != '0) && (lat_valD != '0);

  // A mispredict seen while the pipe is frozen is remembered so the E flush
  // lands on the first cycle the pipe moves again.
  always_comb begin
    pending_redirect_next = 1'b0;
    if (flush_exceptionM)
      pending_redirect_next = 1'b0;
    else if (longest_stall)
      pending_redirect_next = pending_redirect_reg | flush_pred_failedM;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pending_redirect_reg <= 1'b0;
    else
      pending_redirect_reg <= pending_redirect_next;
  end

  // Per-register scoreboard entry: busy flag plus remaining-latency counter.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign busy_vec[gi] = 1'b0;
      end else begin : g_entry
        localparam logic [AW-1:0] IDX = AW'(gi);
        logic          busy_reg;
        logic [LW-1:0] cnt_reg;

        always_ff @(posedge clk) begin
          if (rst) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
          end else if (flush_exceptionM) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
          end else if (alloc && (reg_writeD == IDX)) begin
            // Newer writer replaces any outstanding one.
            busy_reg <= 1'b1;
            cnt_reg  <= lat_valD;
          end else if (!longest_stall && busy_reg) begin
            if (cnt_reg == CNT_ONE) begin
              busy_reg <= 1'b0;
              cnt_reg  <= '0;
            end else begin
              cnt_reg  <= cnt_reg - CNT_ONE;
            end
          end
        end

        assign busy_vec[gi] = busy_reg;
      end
    end
  endgenerate

  assign sb_busy = busy_vec;

endmodule

// File: doc/hazard_sb.md
HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers; register 0 is hard-wired zero.
REQ-002 SHALL have parameter AW, default 5, register-index width; NREG SHALL equal 2**AW.
REQ-003 SHALL have parameter LW, default 3, latency-counter width (max producer latency 2**LW-1).
REQ-004 SHALL have parameter FWD_LOAD_M, default 0; 1 = load data forwardable from M, 0 = load data forwarded only from W.
REQ-005 ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-006 ports: i_stall, d_stall, div_stallE, mult_stallE in 1 each: memory and multi-cycle unit stall requests.
REQ-007 ports: rsD, rtD, rsE, rtE in AW: source indices in D and E.
REQ-008 ports: reg_write_enD in 1; reg_writeD in AW; lat_opD in 1 (long-latency producer); lat_valD in LW (result latency in cycles, valid when lat_opD).
REQ-009 ports: reg_write_enE/M/W in 1; reg_writeE/M/W in AW; loadE, loadM in 1 (instruction in that stage is a load).
REQ-010 ports: flush_pred_failedM, flush_exceptionM in 1.
REQ-011 ports: longest_stall out 1; stallF/D/E/M/W out 1 each; flushF/D/E/M/W out 1 each; forward_aE, forward_bE out 2 (00 regfile, 01 from M, 10 from W); sb_busy out NREG (scoreboard bits, bit 0 always 0).

Function
REQ-012 longest_stall SHALL equal i_stall | d_stall | div_stallE | mult_stallE, combinationally.
REQ-013 forward_aE SHALL be 01 when rsE!=0, reg_write_enM, rsE==reg_writeM, and (FWD_LOAD_M or ~loadM); else 10 when rsE!=0, reg_write_enW, rsE==reg_writeW; else 00. forward_bE is identical using rtE.
REQ-014 load-use stall: ld_hazD SHALL be 1 when loadE, reg_write_enE, reg_writeE!=0, and reg_writeE equals rsD or rtD; when FWD_LOAD_M=0, loadM with the same match on reg_writeM SHALL also set ld_hazD.
REQ-015 scoreboard hazard sb_hazD SHALL be 1 when sb_busy[rsD] or sb_busy[rtD] is set (index 0 excluded).
REQ-016 hazD = (ld_hazD | sb_hazD) & ~flush_exceptionM & ~flush_pred_failedM.
REQ-017 stallF = stallD = longest_stall | hazD; stallE = stallM = stallW = longest_stall.
REQ-018 scoreboard per register: busy bit plus LW-bit down-counter; allocation when ~stallD, lat_opD, reg_write_enD, reg_writeD!=0, lat_valD!=0: busy=1, counter=lat_valD.
REQ-019 each cycle with longest_stall=0, every busy counter SHALL decrement; a counter reaching 0 clears its busy bit in the same edge; with longest_stall=1 counters hold.
REQ-020 allocation to a register that is already busy SHALL overwrite its counter with lat_valD (newer writer wins); allocation and decrement of the same entry in one edge: allocation wins.
REQ-021 flush_exceptionM=1 SHALL clear all busy bits and counters at the next edge; allocations in that cycle are suppressed.
REQ-022 flush_pred_failedM=1 with longest_stall=1 SHALL set a pending_redirect flag; flag clears on the first edge with longest_stall=0, or on flush_exceptionM.
REQ-023 flushF = flushW = 0; flushD = flush_exceptionM; flushE = flush_exceptionM | ((flush_pred_failedM | pending_redirect | hazD) & ~longest_stall); flushM = flush_exceptionM.
REQ-024 all outputs other than sb_busy and pending_redirect-derived terms SHALL be combinational; no added latency on forwarding.

Reset
REQ-025 on rst=1 at a clk edge: all busy bits, counters and pending_redirect SHALL be 0; rst has priority over all other events.
REQ-026 with stall inputs low and no hazard during/after reset, stall* = 0, flush* = 0, forward_* = 00, sb_busy = 0.

Verification
REQ-027 load-use: loadE, reg_writeE=5, rsD=5, FWD_LOAD_M=0 -> stallF=stallD=1, flushE=1 for 1 cycle; next cycle loadM match -> stall again; then forward_aE=10.
REQ-028 scoreboard: issue lat_opD, reg_writeD=8, lat_valD=4, no stalls -> sb_busy[8]=1 for exactly 4 cycles; rtD=8 in that window -> stallD=1, flushE=1.
REQ-029 freeze: busy counter=2, longest_stall high 3 cycles -> counter holds at 2, sb_busy[8] stays 1; then clears 2 cycles after release.
REQ-030 deferred redirect: flush_pred_failedM=1 while i_stall=1 (one cycle), i_stall drops 2 cycles later -> flushE=0 while stalled, flushE=1 exactly in first unstalled cycle.
REQ-031 exception: several registers busy, flush_exceptionM=1 -> sb_busy=0 next cycle, flushD=flushE=flushM=1, hazD forced 0.
REQ-032 reset mid-operation: rst asserted with counters nonzero and pending_redirect=1 -> all cleared next edge; register 0 writes never set sb_busy[0].
